i2s_dac_tx: RTL
===============

I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 SHALL have parameter CLK_DIV_HALF, default 20: clk cycles per o_bclk half-period (120 MHz -> 3 MHz).
REQ-002 SHALL have parameter FRAMES_PER_SAMPLE, default 8: I2S frames per consumed sample (46875 Hz / 8 = 5859.375 Hz).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: input FIFO entries, power of two.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Ports SHALL be:
- clk  in  1  system clock (120 MHz)
- RST  in  1  async reset, active high
- i_data0  in  18  left sample, signed
- i_data1  in  18  right sample, signed
- i_vld  in  1  sample valid
- o_rdy  out  1  FIFO not full
- o_bclk  out  1  I2S bit clock
- o_ws  out  1  word select, 0 = left, 1 = right
- o_sdata  out  1  serial data to DAC
- o_frame  out  1  one-clk pulse at left-slot start
- o_underrun  out  1  sticky FIFO-empty-at-pop flag

Function
REQ-006 SHALL run div counter 0..CLK_DIV_HALF-1; at terminal count, o_bclk SHALL toggle and the counter SHALL wrap to 0.
REQ-007 On each o_bclk 1->0 edge (the falling edge), bit_count SHALL advance 0..31 and wrap; on the 31->0 wrap, o_ws SHALL toggle.
REQ-008 o_sdata SHALL change only on falling edges: new bit_count b=1..18 -> slot bit (18-b), MSB first; b=0 and b=19..31 -> 0.
REQ-009 On the falling edge where o_ws goes 1->0, the left and right shift registers SHALL load from the held sample pair, and o_frame SHALL pulse for 1 clk.
REQ-010 A frame counter SHALL count 0..FRAMES_PER_SAMPLE-1 at each frame start; at frame start with count 0, the FIFO head SHALL pop into the held pair before the REQ-009 load in the same cycle.
REQ-011 Pop with FIFO empty SHALL keep the held pair (repeat) and set o_underrun; only RST clears o_underrun.
REQ-012 o_rdy SHALL be 1 when FIFO count < FIFO_DEPTH; a push SHALL occur when i_vld && o_rdy; i_vld with o_rdy=0 SHALL be ignored (no write).
REQ-013 Simultaneous push and pop: when full, the pop proceeds and the push is refused (o_rdy=0 that cycle); when empty, underrun is flagged and the push is stored.
REQ-014 Latency: a sample pushed into an empty FIFO SHALL appear on o_sdata at the MSB bit of the first left slot that follows the next pop frame.
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL use log2(FIFO_DEPTH)+1 bits.

Reset
REQ-016 RST=1 SHALL immediately force o_bclk=0, o_ws=0, o_sdata=0, o_frame=0, o_underrun=0, o_rdy=1, all counters=0, FIFO empty, held pair=0.
REQ-017 RST asserted mid-slot SHALL abort the slot; after release, the first frame SHALL begin from bit_count 0 with the left slot.

Configuration
REQ-018 Macro I2S_DAC_TX_STEREO_EN: when defined, FIFO width SHALL be 36 and the right slot SHALL carry i_data1; when undefined, FIFO width SHALL be 18, i_data1 SHALL be ignored, and the right slot SHALL duplicate the left sample.

Verification
REQ-019 Release RST, i_vld=0 -> o_bclk period 40 clk, o_ws period 2560 clk, o_rdy=1, o_sdata=0, o_underrun=1 after first frame.
REQ-020 Push i_data0=18'h2AAAA, i_data1=18'h15555 -> left slot bits 1..18 = 101010101010101010, right slot bits 1..18 = 010101010101010101, bits 19..31 = 0.
REQ-021 Push 5 samples back-to-back before any pop -> o_rdy=0 after 4th push; 5th accepted only after next pop; samples emerge in push order.
REQ-022 Push one sample, withhold the next for 16 frames -> sample repeated for 16 frames, o_underrun=1 at second pop, stays 1.
REQ-023 Assert RST at bit_count 10 of a right slot -> o_bclk, o_ws, o_sdata = 0 within the same cycle, FIFO empty, o_rdy=1.
REQ-024 Macro undefined: i_data0=18'h00001, i_data1=18'h3FFFF -> both slots carry 000000000000000001.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: FIFO-fed 18-bit I2S transmitter; define I2S_DAC_TX_STEREO_EN for an independent right channel
module i2s_dac_tx #(
  parameter int CLK_DIV_HALF      = 20,
  parameter int FRAMES_PER_SAMPLE = 8,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [17:0] i_data0,
  input  logic [17:0] i_data1,
  input  logic        i_vld,
  output logic        o_rdy,
  output logic        o_bclk,
  output logic        o_ws,
  output logic        o_sdata,
  output logic        o_frame,
  output logic        o_underrun
);
`ifdef I2S_DAC_TX_STEREO_EN
  localparam int W = 36;
`else
  localparam int W = 18;
`endif
  localparam int DW = CLK_DIV_HALF > 1 ? $clog2(CLK_DIV_HALF) : 1;
  localparam int FW = FRAMES_PER_SAMPLE > 1 ? $clog2(FRAMES_PER_SAMPLE) : 1;
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [W-1:0]  wdata, head, held_q, held_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [17:0]   left_q, left_d, right_q, right_d, ld_r;
  logic bclk_q, bclk_d, ws_q, ws_d, sd_q, sd_d, frame_q, frame_d, und_q, und_d;
  logic tc, fall, fstart, pop, popok, push, act;
`ifdef I2S_DAC_TX_STEREO_EN
  assign wdata = {i_data1, i_data0};
  assign ld_r  = held_d[35:18];
`else
  logic unused_d1;
  assign unused_d1 = ^i_data1;
  assign wdata = i_data0;
  assign ld_r  = held_d[17:0];
`endif
  assign o_rdy      = cnt_q < CW'(FIFO_DEPTH);
  assign o_bclk     = bclk_q;
  assign o_ws       = ws_q;
  assign o_sdata    = sd_q;
  assign o_frame    = frame_q;
  assign o_underrun = und_q;
  // bit clock, slot sequencing, FIFO bookkeeping and serializer next state
  always_comb begin
    tc      = div_q == DW'(CLK_DIV_HALF - 1);
    fall    = tc && bclk_q;
    fstart  = fall && bit_q == 5'd31 && ws_q;
    pop     = fstart && fcnt_q == '0;
    popok   = pop && cnt_q != '0;
    push    = i_vld && o_rdy;
    head    = mem_q[rd_q];
    div_d   = tc ? '0 : div_q + DW'(1);
    bclk_d  = bclk_q ^ tc;
    bit_d   = fall ? bit_q + 5'd1 : bit_q;
    ws_d    = ws_q ^ (fall && bit_q == 5'd31);
    fcnt_d  = !fstart ? fcnt_q : fcnt_q == FW'(FRAMES_PER_SAMPLE - 1) ? '0 : fcnt_q + FW'(1);
    held_d  = popok ? head : held_q;
    und_d   = und_q || (pop && cnt_q == '0);
    rd_d    = rd_q + AW'(popok);
    wr_d    = wr_q + AW'(push);
    cnt_d   = cnt_q + CW'(push) - CW'(popok);
    act     = bit_d >= 5'd1 && bit_d <= 5'd18;
    left_d  = fstart ? held_d[17:0] : (fall && !ws_d && act) ? {left_q[16:0], 1'b0} : left_q;
    right_d = fstart ? ld_r : (fall && ws_d && act) ? {right_q[16:0], 1'b0} : right_q;
    sd_d    = fall ? act && (ws_d ? right_q[17] : left_q[17]) : sd_q;
    frame_d = fstart;
  end
  // FIFO storage needs no reset; emptiness is tracked by the pointers
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= wdata;
  // state registers, all cleared immediately by RST
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      bit_q   <= '0;
      ws_q    <= 1'b0;
      fcnt_q  <= '0;
      held_q  <= '0;
      und_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      sd_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      bit_q   <= bit_d;
      ws_q    <= ws_d;
      fcnt_q  <= fcnt_d;
      held_q  <= held_d;
      und_q   <= und_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      right_q <= right_d;
      sd_q    <= sd_d;
      frame_q <= frame_d;
    end
  end
endmodule
